nic_io_sched: RTL
=================

Name: nic_io_sched

Overview:
- Hardware scheduler between local producer/consumer logic and the NIC's processor-side register interface: addr 00 = in-ch buffer, 01 = in-ch status, 10 = out-ch buffer, 11 = out-ch status.
- Buffers outgoing 64-bit packets in a TX FIFO.
- Polls NIC out-channel status and writes a packet when the out-channel is free.
- Polls NIC in-channel status and drains the in-channel buffer into an RX FIFO.
- Sits beside the NIC in place of processor load/store sequencing and is the sole master of the NIC processor port.

Parameters:
- TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
- RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
- CNT_W, 16, width of packet statistics counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- sched_en  in  1  1 = scheduler may start new NIC transactions
- tx_valid  in  1  producer has packet
- tx_ready  out  1  TX FIFO not full
- tx_data  in  64  packet (bit 63 = VC/polarity bit, passed untouched)
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  consumer pops head
- rx_data  out  64  RX FIFO head (first-word fall-through)
- nic_addr  out  2  to NIC addr
- nic_en  out  1  to NIC nicEN
- nic_wr_en  out  1  to NIC nicWrEn
- nic_wdata  out  64  to NIC d_in
- nic_rdata  in  64  from NIC d_out; valid the cycle after a read (nic_en=1, nic_wr_en=0)
- tx_cnt  out  CNT_W  packets written to NIC, wraps
- rx_cnt  out  CNT_W  packets read from NIC, wraps

Behaviour:
- Reset values:
  - State IDLE; both FIFOs empty; tx_ready=1, rx_valid=0.
  - nic_en=0, nic_wr_en=0, nic_addr=00, nic_wdata=0.
  - tx_cnt=rx_cnt=0; last_srv=RX, so TX wins the first tie.
- NIC outputs are combinational decodes of state (plus TX head for nic_wdata). In non-write states nic_wdata=0 and nic_wr_en=0.
- FSM states and per-state outputs:
  - IDLE: nic_en=0.
  - O_POLL: nic_en=1, addr=11, wr=0.
  - O_CHK: nic_en=0; sample nic_rdata[63].
  - O_WR: nic_en=1, wr=1, addr=10, wdata=TX head; pop TX; tx_cnt+1.
  - I_POLL: nic_en=1, addr=01, wr=0.
  - I_CHK: nic_en=0; sample nic_rdata[63].
  - I_RD: nic_en=1, addr=00, wr=0.
  - I_CAP: nic_en=0, wr=0; push nic_rdata into RX FIFO; rx_cnt+1.
- IDLE arbitration (evaluated only when sched_en=1):
  - tx_req = TX FIFO not empty; rx_req = RX FIFO not full.
  - Both requesting: serve the side opposite last_srv.
  - Single requester: serve it. Neither: stay in IDLE.
  - Go to O_POLL (sets last_srv=TX) or I_POLL (sets last_srv=RX).
- Transitions:
  - O_POLL->O_CHK.
  - O_CHK: bit63=0 -> O_WR; bit63=1 (busy) -> IDLE.
  - O_WR->IDLE.
  - I_POLL->I_CHK.
  - I_CHK: bit63=1 -> I_RD; bit63=0 -> IDLE.
  - I_RD->I_CAP->IDLE.
- NIC coupling rules:
  - nic_wr_en must be 0 in I_CAP. The NIC clears in-ch status on a buffer read using the current-cycle write enable.
  - O_WR is entered only after status 0 was observed. Only this block writes the out-channel, so the write is always accepted.
- Latency:
  - TX packet to NIC write: 4 cycles minimum from push (FIFO write, IDLE, O_POLL, O_CHK, O_WR).
  - NIC in-ch full to rx_valid: 5 cycles minimum (I_POLL, I_CHK, I_RD, I_CAP, FIFO visible next cycle).
- Busy NIC: O_CHK returns to IDLE, and the RX side is offered next if requesting. This gives no starvation.
- RX FIFO full: I_POLL is never entered. The NIC in-channel stays full and back-pressures the router.
- sched_en deassert mid-transaction: the current sequence completes to IDLE. No new transaction starts.
- FIFOs:
  - Push when valid&&ready, pop when ready&&valid. Simultaneous push+pop is legal when neither full nor empty; count unchanged.
  - tx_ready is !full from the registered count, with no full-bypass.
  - RX FIFO push happens only in I_CAP. I_POLL entry guarantees space, because rx_ready can only drain.
- Counters wrap from 2^CNT_W-1 to 0.
- Reset mid-operation: any in-flight sequence is abandoned. FIFO contents are discarded and all outputs return to reset values on the next edge. The NIC shares the same reset.

Decomposition:
- Shared package nic_pkg:
  - NIC register address constants: NIC_IN_BUF=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_BUF=2'b10, NIC_OUT_STAT=2'b11.
  - NIC_STAT_BIT=63.
  - FSM state encoding type.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; FWFT, registered count), instantiated twice for TX and RX.

Test Plan:
- Reset, then push tx_data=64'h8000_0000_0000_00A5 with the NIC out-ch empty -> cycle sequence O_POLL/O_CHK/O_WR; nic_wdata=64'h8000_0000_0000_00A5 with nic_en=nic_wr_en=1, addr=10; tx_cnt=1.
- Out-ch held busy (NIC model returns bit63=1 for addr 11) with 3 queued packets -> no addr-10 write occurs; tx_ready stays 1; TX FIFO holds 3. Release the NIC -> the 3 packets are written in push order.
- Router delivers 64'h0000_0000_1234_5678 into the NIC -> I_POLL/I_CHK/I_RD/I_CAP; nic_wr_en=0 in I_CAP; NIC in-status clears; rx_valid=1 with rx_data=64'h0000_0000_1234_5678; rx_cnt=1.
- TX non-empty and RX side continuously requesting -> NIC transactions alternate TX/RX. The first served after reset is TX.
- rx_ready=0 with 4 packets received (RX_DEPTH=4) -> no further addr-01 reads; the 5th packet is held in the NIC (net_ri low). Pop one -> the 5th is drained.
- Assert reset during O_CHK with 2 TX packets queued -> next cycle nic_en=0, tx_ready=1, rx_valid=0, counters 0; no NIC write occurs afterwards.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared definitions for the NIC I/O scheduler: NIC register map,
// status-bit position and the scheduler state encoding.
package nic_pkg;

  // NIC processor-side register map
  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Status registers report full/busy in the top bit
  localparam int NIC_STAT_BIT = 63;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_O_POLL = 3'd1,
    ST_O_CHK  = 3'd2,
    ST_O_WR   = 3'd3,
    ST_I_POLL = 3'd4,
    ST_I_CHK  = 3'd5,
    ST_I_RD   = 3'd6,
    ST_I_CAP  = 3'd7
  } sched_state_e;

  // Which side was served last; used for round-robin in IDLE
  typedef enum logic {
    SRV_TX = 1'b0,
    SRV_RX = 1'b1
  } srv_side_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy
// count. Full/empty come straight from the count, so there is no
// same-cycle full bypass.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; contents are discarded by resetting the count
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nic_io_sched.sv
// NIC I/O scheduler: sole master of the NIC processor port. Buffers
// outgoing packets and writes them when the out-channel is free; drains
// the in-channel into an RX FIFO when it reports full.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | no NIC access; round-robin pick of TX or RX side
// O_POLL  | read out-channel status
// O_CHK   | inspect out status: free -> write, busy -> back off
// O_WR    | write TX head to out-channel buffer, pop TX FIFO
// I_POLL  | read in-channel status
// I_CHK   | inspect in status: full -> read buffer, empty -> back off
// I_RD    | read in-channel buffer (NIC clears its in status)
// I_CAP   | capture returned packet into RX FIFO
module nic_io_sched
  import nic_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sched_en,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [63:0]      tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [63:0]      rx_data,
  output logic [1:0]       nic_addr,
  output logic             nic_en,
  output logic             nic_wr_en,
  output logic [63:0]      nic_wdata,
  input  logic [63:0]      nic_rdata,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt
);

  sched_state_e     state_q, state_d;
  srv_side_e        last_srv_q, last_srv_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;

  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [63:0] tx_head;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        tx_req, rx_req;
  logic        stat_bit;

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign tx_push  = tx_valid && !tx_full;
  assign rx_pop   = rx_ready && !rx_empty;
  assign tx_req   = !tx_empty;
  assign rx_req   = !rx_full;
  assign stat_bit = nic_rdata[NIC_STAT_BIT];
  assign tx_cnt   = tx_cnt_q;
  assign rx_cnt   = rx_cnt_q;

  sync_fifo #(.WIDTH(64), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .wdata_i (tx_data),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  sync_fifo #(.WIDTH(64), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .wdata_i (nic_rdata),
    .pop_i   (rx_pop),
    .rdata_o (rx_data),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Next-state: round-robin arbitration in IDLE, fixed NIC access sequences
  always_comb begin
    state_d    = state_q;
    last_srv_d = last_srv_q;
    case (state_q)
      ST_IDLE: begin
        if (sched_en) begin
          if (tx_req && (!rx_req || last_srv_q == SRV_RX)) begin
            state_d    = ST_O_POLL;
            last_srv_d = SRV_TX;
          end else if (rx_req) begin
            state_d    = ST_I_POLL;
            last_srv_d = SRV_RX;
          end
        end
      end
      ST_O_POLL: state_d = ST_O_CHK;
      ST_O_CHK:  state_d = stat_bit ? ST_IDLE : ST_O_WR;
      ST_O_WR:   state_d = ST_IDLE;
      ST_I_POLL: state_d = ST_I_CHK;
      ST_I_CHK:  state_d = stat_bit ? ST_I_RD : ST_IDLE;
      ST_I_RD:   state_d = ST_I_CAP;
      ST_I_CAP:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // NIC port drive and FIFO strobes decoded from the current state
  always_comb begin
    nic_en    = 1'b0;
    nic_wr_en = 1'b0;
    nic_addr  = NIC_IN_BUF;
    nic_wdata = '0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    case (state_q)
      ST_O_POLL: begin
        nic_en   = 1'b1;
        nic_addr = NIC_OUT_STAT;
      end
      ST_O_WR: begin
        nic_en    = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = NIC_OUT_BUF;
        nic_wdata = tx_head;
        tx_pop    = 1'b1;
      end
      ST_I_POLL: begin
        nic_en   = 1'b1;
        nic_addr = NIC_IN_STAT;
      end
      ST_I_RD: begin
        nic_en   = 1'b1;
        nic_addr = NIC_IN_BUF;
      end
      // Write enable must stay low here: the NIC clears in-status on the read
      ST_I_CAP: rx_push = 1'b1;
      default: ;
    endcase
  end

  // Packet statistics, wrapping naturally at 2^CNT_W
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_pop)  tx_cnt_d = tx_cnt_q + CNT_W'(1);
    if (rx_push) rx_cnt_d = rx_cnt_q + CNT_W'(1);
  end

  // State, arbitration history and counters; RX starts as last served so TX wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_srv_q <= SRV_RX;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_srv_q <= last_srv_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

endmodule
